div_seq: RTL

- Sequential restoring divider, the inverse operation of the team's combinational 8x8 array multiplier.
- Divides a 2N-bit unsigned dividend by an N-bit unsigned divisor.
- Produces one quotient bit per clock, yielding a 2N-bit quotient and an N-bit remainder.
- Used in the lab datapath wherever a product must be decomposed again, e.g. checking mul8x8 results as (p / y == x, remainder 0).

---
 rtl/div_seq_if.sv | 41 ++++
 rtl/div_seq.sv | 151 +++++++++++++++
 2 files changed

// File: rtl/div_seq_if.sv
// -----------------------------------------------------------------------------
// div_seq_if
// Handshake and data bundle for the sequential restoring divider.
//
// Parameter:
//   N          divisor/remainder width (dividend/quotient are 2N)
//
// Signals:
//   start      request, sampled only while the divider is idle
//   dividend   2N-bit unsigned dividend, sampled on the accepting edge
//   divisor    N-bit unsigned divisor, sampled on the accepting edge
//   busy       high while an operation is in progress
//   done       one-cycle pulse when quotient/remainder become valid
//   quotient   2N-bit result, held until the next accept
//   remainder  N-bit result, held until the next accept
//   dz         divide-by-zero flag, valid with done
//
// Modports: master = requester, slave = divider.
// -----------------------------------------------------------------------------
interface div_seq_if #(
    parameter int N = 8
);
    logic             start;
    logic [2*N-1:0]   dividend;
    logic [N-1:0]     divisor;
    logic             busy;
    logic             done;
    logic [2*N-1:0]   quotient;
    logic [N-1:0]     remainder;
    logic             dz;

    modport master (
        output start, dividend, divisor,
        input  busy, done, quotient, remainder, dz
    );

    modport slave (
        input  start, dividend, divisor,
        output busy, done, quotient, remainder, dz
    );
endinterface

// File: rtl/div_seq.sv
// -----------------------------------------------------------------------------
// div_seq
// Sequential restoring divider: 2N-bit unsigned dividend / N-bit unsigned
// divisor, one quotient bit per clock, 2N iterations per operation.
//
// Ports:
//   clk     rising-edge clock
//   rst_n   asynchronous active-low reset
//   bus     div_seq_if.slave (start/dividend/divisor in,
//           busy/done/quotient/remainder/dz out)
//
// Optional feature (macro DIV_ZERO_CHECK_EN):
//   defined     - a zero divisor skips the iterations; the result appears one
//                 cycle after accept with dz=1.
//   undefined   - dz is tied low; a zero divisor runs the full 2N iterations,
//                 which naturally yields quotient=all ones and
//                 remainder=dividend[N-1:0].
//
// State   | meaning
// --------+-------------------------------------------------------------
// IDLE    | waiting for start; results held
// RUN     | iterating, one quotient bit per clock, counter counts down
// -----------------------------------------------------------------------------
module div_seq #(
    parameter int N = 8
) (
    input  logic     clk,
    input  logic     rst_n,
    div_seq_if.slave bus
);
    localparam int CW = $clog2(2*N + 1);

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_e;

    state_e           state_q;
    logic [N-1:0]     d_q;
    logic [2*N-1:0]   sr_q;          // dividend bits out the top, quotient bits in at the bottom
    logic [N:0]       r_q;
    logic [CW-1:0]    cnt_q;
    logic             busy_q;
    logic             done_q;
    logic [2*N-1:0]   quotient_q;
    logic [N-1:0]     remainder_q;
`ifdef DIV_ZERO_CHECK_EN
    logic             dz_q;
    logic             zchk_q;        // accepted with divisor 0: finish on the next edge
`endif

    // One restoring step: shift the next dividend bit into the partial
    // remainder and try to subtract the divisor.
    logic [N:0]       shifted;
    logic [N+1:0]     diff;
    logic             borrow;
    logic             qbit;
    logic [N:0]       r_next;

    always_comb begin
        shifted = {r_q[N-1:0], sr_q[2*N-1]};
        diff    = {1'b0, shifted} - {2'b00, d_q};
        borrow  = diff[N+1];
        qbit    = ~borrow;
        r_next  = borrow ? shifted : diff[N:0];
    end

    // r stays strictly below d, so its top bit never feeds the next step.
    logic unused_r_msb;
    assign unused_r_msb = r_q[N];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            d_q         <= '0;
            sr_q        <= '0;
            r_q         <= '0;
            cnt_q       <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            quotient_q  <= '0;
            remainder_q <= '0;
`ifdef DIV_ZERO_CHECK_EN
            dz_q        <= 1'b0;
            zchk_q      <= 1'b0;
`endif
        end else begin
            done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (bus.start) begin
                        d_q     <= bus.divisor;
                        sr_q    <= bus.dividend;
                        r_q     <= '0;
                        cnt_q   <= CW'(2*N);
                        busy_q  <= 1'b1;
                        state_q <= RUN;
`ifdef DIV_ZERO_CHECK_EN
                        dz_q    <= 1'b0;
                        zchk_q  <= (bus.divisor == '0);
                        if (bus.divisor == '0) begin
                            cnt_q <= CW'(1);
                        end
`endif
                    end
                end

                RUN: begin
`ifdef DIV_ZERO_CHECK_EN
                    if (zchk_q) begin
                        // The dividend is still untouched in sr_q.
                        quotient_q  <= '1;
                        remainder_q <= sr_q[N-1:0];
                        dz_q        <= 1'b1;
                        zchk_q      <= 1'b0;
                        cnt_q       <= '0;
                        busy_q      <= 1'b0;
                        done_q      <= 1'b1;
                        state_q     <= IDLE;
                    end else
`endif
                    begin
                        r_q   <= r_next;
                        sr_q  <= {sr_q[2*N-2:0], qbit};
                        cnt_q <= cnt_q - CW'(1);
                        if (cnt_q == CW'(1)) begin
                            quotient_q  <= {sr_q[2*N-2:0], qbit};
                            remainder_q <= r_next[N-1:0];
                            busy_q      <= 1'b0;
                            done_q      <= 1'b1;
                            state_q     <= IDLE;
                        end
                    end
                end

                default: state_q <= IDLE;
            endcase
        end
    end

    assign bus.busy      = busy_q;
    assign bus.done      = done_q;
    assign bus.quotient  = quotient_q;
    assign bus.remainder = remainder_q;
`ifdef DIV_ZERO_CHECK_EN
    assign bus.dz        = dz_q;
`else
    assign bus.dz        = 1'b0;
`endif

endmodule
